// File: rtl/accum_stat_reg.sv
// Accumulator status register: sign/zero flags, sticky overflow with
// saturating event counter, BIO synchroniser and branch condition unit.
module accum_stat_reg #(
  parameter int ACC_W       = 32,
  parameter int AR_W        = 16,
  parameter int SYNC_STAGES = 2,
  parameter int OVC_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc_upd,
  input  logic [ACC_W-1:0] accum,
  input  logic             ov_in,
  input  logic             ov_clr,
  input  logic [AR_W-1:0]  ar,
  input  logic             bio,
  input  logic             cond_req,
  input  logic [3:0]       cond_sel,
  output logic             cond_valid,
  output logic             cond_true,
  output logic             gez,
  output logic             gz,
  output logic             nz,
  output logic             z,
  output logic             lz,
  output logic             lez,
  output logic             ov,
  output logic [OVC_W-1:0] ov_cnt,
  output logic             arnz,
  output logic             bioz
);

  localparam logic [OVC_W-1:0] CNT_ONE = {{(OVC_W-1){1'b0}}, 1'b1};

  logic                   z_q, z_d;
  logic                   lz_q, lz_d;
  logic                   ov_q, ov_d;
  logic [OVC_W-1:0]       ov_cnt_q, ov_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   cond_valid_q, cond_valid_d;
  logic                   cond_true_q, cond_true_d;

  logic             ov_set;
  logic             bv_clr;
  logic [OVC_W-1:0] cnt_base;
  logic             hit;

  // Only sign and zero are stored; the rest follow, so invariants hold.
  assign z    = z_q;
  assign lz   = lz_q;
  assign nz   = ~z_q;
  assign gz   = ~lz_q & ~z_q;
  assign gez  = ~lz_q;
  assign lez  = lz_q | z_q;
  assign ov   = ov_q;
  assign ov_cnt = ov_cnt_q;
  assign arnz = (ar != '0);
  assign bioz = ~sync_q[SYNC_STAGES-1];
  assign cond_valid = cond_valid_q;
  assign cond_true  = cond_true_q;

  always_comb begin
    hit = 1'b0;
    unique case (cond_sel)
      4'd0:    hit = 1'b1;
      4'd1:    hit = z;
      4'd2:    hit = nz;
      4'd3:    hit = gz;
      4'd4:    hit = gez;
      4'd5:    hit = lz;
      4'd6:    hit = lez;
      4'd7:    hit = ov_q;
      4'd8:    hit = arnz;
      4'd9:    hit = bioz;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    z_d  = z_q;
    lz_d = lz_q;
    if (acc_upd) begin
      z_d  = (accum == '0);
      lz_d = accum[ACC_W-1];
    end
    ov_set = acc_upd & ov_in;
    bv_clr = cond_req & (cond_sel == 4'd7);
    ov_d   = ov_q;
    if (ov_set)
      ov_d = 1'b1;
    else if (ov_clr | bv_clr)
      ov_d = 1'b0;
    cnt_base = ov_clr ? '0 : ov_cnt_q;
    ov_cnt_d = cnt_base;
    if (ov_set && !(&cnt_base))
      ov_cnt_d = cnt_base + CNT_ONE;
    sync_d       = {sync_q[SYNC_STAGES-2:0], bio};
    cond_valid_d = cond_req;
    cond_true_d  = cond_req & hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z_q          <= 1'b1;
      lz_q         <= 1'b0;
      ov_q         <= 1'b0;
      ov_cnt_q     <= '0;
      sync_q       <= '1;
      cond_valid_q <= 1'b0;
      cond_true_q  <= 1'b0;
    end else begin
      z_q          <= z_d;
      lz_q         <= lz_d;
      ov_q         <= ov_d;
      ov_cnt_q     <= ov_cnt_d;
      sync_q       <= sync_d;
      cond_valid_q <= cond_valid_d;
      cond_true_q  <= cond_true_d;
    end
  end

endmodule

// File: tb/tb_accum_stat_reg.sv
// Directed self-checking bench for accum_stat_reg.
module tb_accum_stat_reg;

  localparam int ACC_W = 32;
  localparam int AR_W  = 16;
  localparam int SS    = 2;
  localparam int OVC_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             acc_upd;
  logic [ACC_W-1:0] accum;
  logic             ov_in;
  logic             ov_clr;
  logic [AR_W-1:0]  ar;
  logic             bio;
  logic             cond_req;
  logic [3:0]       cond_sel;
  logic             cond_valid, cond_true;
  logic             gez, gz, nz, z, lz, lez;
  logic             ov;
  logic [OVC_W-1:0] ov_cnt;
  logic             arnz, bioz;

  int nchecks = 0;
  int nerr    = 0;

  logic [5:0] flags;
  assign flags = {z, gez, lez, nz, gz, lz};

  always #5 clk = ~clk;

  accum_stat_reg #(
    .ACC_W(ACC_W), .AR_W(AR_W), .SYNC_STAGES(SS), .OVC_W(OVC_W)
  ) dut (
    .clk(clk), .reset(reset), .acc_upd(acc_upd), .accum(accum),
    .ov_in(ov_in), .ov_clr(ov_clr), .ar(ar), .bio(bio),
    .cond_req(cond_req), .cond_sel(cond_sel),
    .cond_valid(cond_valid), .cond_true(cond_true),
    .gez(gez), .gz(gz), .nz(nz), .z(z), .lz(lz), .lez(lez),
    .ov(ov), .ov_cnt(ov_cnt), .arnz(arnz), .bioz(bioz)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; acc_upd = 1'b0; accum = '0; ov_in = 1'b0;
    ov_clr = 1'b0; ar = '0; bio = 1'b1; cond_req = 1'b0; cond_sel = '0;
    step(); step();
    nchecks++;
    if (flags !== 6'b111000) begin
      nerr++; $display("FAIL reset_flags got %b exp %b", flags, 6'b111000);
    end
    nchecks++;
    if ({ov, ov_cnt} !== 5'b0) begin
      nerr++; $display("FAIL reset_ov got %b exp %b", {ov, ov_cnt}, 5'b0);
    end
    nchecks++;
    if ({bioz, cond_valid, cond_true} !== 3'b000) begin
      nerr++; $display("FAIL reset_misc got %b exp 000", {bioz, cond_valid, cond_true});
    end
    reset = 1'b0;
  endtask

  task automatic test_flags();
    logic [ACC_W-1:0] vals [4] = '{32'h8000_0000, 32'h0000_0001, 32'h0, 32'hFFFF_FFFF};
    logic [5:0]       exps [4] = '{6'b001101, 6'b010110, 6'b111000, 6'b111000};
    for (int i = 0; i < 4; i++) begin
      acc_upd = (i != 3);
      accum = vals[i];
      step();
      nchecks++;
      if (flags !== exps[i]) begin
        nerr++; $display("FAIL flags_%0d got %b exp %b", i, flags, exps[i]);
      end
    end
    acc_upd = 1'b0;
  endtask

  task automatic test_overflow();
    acc_upd = 1'b1; accum = 32'h1; ov_in = 1'b1;
    for (int i = 0; i < 17; i++) step();
    nchecks++;
    if ({ov, ov_cnt} !== {1'b1, 4'd15}) begin
      nerr++; $display("FAIL ov_sat got %b/%0d exp 1/15", ov, ov_cnt);
    end
    ov_clr = 1'b1;
    step();
    nchecks++;
    if ({ov, ov_cnt} !== {1'b1, 4'd1}) begin
      nerr++; $display("FAIL ov_clr_set got %b/%0d exp 1/1", ov, ov_cnt);
    end
    acc_upd = 1'b0; ov_in = 1'b0;
    step();
    nchecks++;
    if ({ov, ov_cnt} !== {1'b0, 4'd0}) begin
      nerr++; $display("FAIL ov_clr got %b/%0d exp 0/0", ov, ov_cnt);
    end
    ov_clr = 1'b0;
  endtask

  task automatic test_bv();
    acc_upd = 1'b1; ov_in = 1'b1; accum = 32'h1;
    step();
    acc_upd = 1'b0; ov_in = 1'b0;
    cond_req = 1'b1; cond_sel = 4'd7;
    step();
    nchecks++;
    if ({cond_valid, cond_true, ov, ov_cnt} !== {3'b110, 4'd1}) begin
      nerr++; $display("FAIL bv_first got %b%b%b/%0d exp 110/1", cond_valid, cond_true, ov, ov_cnt);
    end
    step();
    nchecks++;
    if ({cond_valid, cond_true, ov} !== 3'b100) begin
      nerr++; $display("FAIL bv_second got %b exp 100", {cond_valid, cond_true, ov});
    end
    acc_upd = 1'b1; ov_in = 1'b1;
    step();
    nchecks++;
    if ({ov, ov_cnt} !== {1'b1, 4'd2}) begin
      nerr++; $display("FAIL bv_set_wins got %b/%0d exp 1/2", ov, ov_cnt);
    end
    acc_upd = 1'b0; ov_in = 1'b0; cond_req = 1'b0;
    step();
    nchecks++;
    if ({cond_valid, cond_true} !== 2'b00) begin
      nerr++; $display("FAIL bv_idle got %b exp 00", {cond_valid, cond_true});
    end
  endtask

  task automatic test_conditions();
    logic [3:0]      sels [4] = '{4'd8, 4'd8, 4'd12, 4'd0};
    logic [AR_W-1:0] ars  [4] = '{16'h0, 16'h5, 16'h5, 16'h0};
    logic            exps [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      cond_req = 1'b1; cond_sel = sels[i]; ar = ars[i];
      step();
      nchecks++;
      if ({cond_valid, cond_true} !== {1'b1, exps[i]}) begin
        nerr++; $display("FAIL cond_%0d got %b exp %b", i, {cond_valid, cond_true}, {1'b1, exps[i]});
      end
    end
    cond_req = 1'b0; acc_upd = 1'b1; accum = '0;
    step();
    cond_req = 1'b1; cond_sel = 4'd1; accum = 32'd5;
    step();
    nchecks++;
    if ({cond_valid, cond_true} !== 2'b11) begin
      nerr++; $display("FAIL cond_old_flags got %b exp 11", {cond_valid, cond_true});
    end
    acc_upd = 1'b0;
    step();
    nchecks++;
    if ({cond_valid, cond_true} !== 2'b10) begin
      nerr++; $display("FAIL cond_bz_new got %b exp 10", {cond_valid, cond_true});
    end
    cond_sel = 4'd3;
    step();
    nchecks++;
    if ({cond_valid, cond_true} !== 2'b11) begin
      nerr++; $display("FAIL cond_bgz got %b exp 11", {cond_valid, cond_true});
    end
    cond_req = 1'b0;
  endtask

  task automatic test_bio();
    bio = 1'b0;
    for (int i = 1; i < SS; i++) begin
      step();
      nchecks++;
      if (bioz !== 1'b0) begin
        nerr++; $display("FAIL bio_early_%0d got %b exp 0", i, bioz);
      end
    end
    step();
    nchecks++;
    if (bioz !== 1'b1) begin
      nerr++; $display("FAIL bio_latency got %b exp 1", bioz);
    end
    cond_req = 1'b1; cond_sel = 4'd9;
    step();
    cond_req = 1'b0;
    nchecks++;
    if ({cond_valid, cond_true} !== 2'b11) begin
      nerr++; $display("FAIL bioz_cond got %b exp 11", {cond_valid, cond_true});
    end
    bio = 1'b1;
    for (int i = 0; i < SS + 1; i++) step();
    bio = 1'b0;
    step();
    bio = 1'b1;
    for (int i = 1; i < SS; i++) step();
    nchecks++;
    if (bioz !== 1'b1) begin
      nerr++; $display("FAIL bio_glitch got %b exp 1", bioz);
    end
    step();
    nchecks++;
    if (bioz !== 1'b0) begin
      nerr++; $display("FAIL bio_glitch_end got %b exp 0", bioz);
    end
    bio = 1'b0;
    for (int i = 1; i < SS; i++) step();
    reset = 1'b1; cond_req = 1'b1; cond_sel = 4'd0;
    step();
    nchecks++;
    if ({bioz, cond_valid, cond_true} !== 3'b000) begin
      nerr++; $display("FAIL bio_reset got %b exp 000", {bioz, cond_valid, cond_true});
    end
    reset = 1'b0; cond_req = 1'b0; bio = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_flags();
    test_overflow();
    test_bv();
    test_conditions();
    test_bio();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/accum_stat_reg.md
Name: accum_stat_reg

Overview:
Parametrised, registered accumulator status unit for the tiny DSP core. It captures the accumulator sign and zero flags on each accumulator write and holds a sticky overflow flag with a saturating overflow-event counter. It synchronises the asynchronous BIO pin. It evaluates branch conditions (B, BZ, BNZ, BGZ, BGEZ, BLZ, BLEZ, BV, BANZ, BIOZ) with a one-cycle request/valid handshake for the branch/fetch logic.

Parameters:
ACC_W, 32, accumulator width; sign bit is accum[ACC_W-1]
AR_W, 16, selected auxiliary register width
SYNC_STAGES, 2, BIO synchroniser depth (minimum 2)
OVC_W, 4, overflow event counter width (saturating)

Ports:
clk  input  1  core clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
acc_upd  input  1  accumulator written this cycle; sample accum/ov_in
accum  input  ACC_W  new accumulator value (valid when acc_upd=1)
ov_in  input  1  ALU overflow for this update (valid when acc_upd=1)
ov_clr  input  1  clear sticky overflow and counter
ar  input  AR_W  selected auxiliary register (sampled on cond_req)
bio  input  1  asynchronous BIO pin, active low
cond_req  input  1  condition evaluation request (single-cycle pulse)
cond_sel  input  4  condition code
cond_valid  output  1  result valid, one cycle after cond_req
cond_true  output  1  condition result, qualified by cond_valid
gez, gz, nz, z, lz, lez  output  1 each  registered accumulator status
ov  output  1  sticky overflow
ov_cnt  output  OVC_W  saturating overflow event count
arnz  output  1  combinational (ar != 0)
bioz  output  1  synchronised BIO is 0

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - z=1, gez=1, lez=1, nz=0, gz=0, lz=0 (an accumulator reset to 0).
  - ov=0, ov_cnt=0, cond_valid=0, cond_true=0.
  - All BIO sync flops=1, so bioz=0.
  - Reset overrides every other input in the same cycle. A cond_req coincident with reset is dropped.
- Flag capture, when acc_upd=1 at an edge:
  - sign = accum[ACC_W-1]; zero = (accum == 0).
  - lz = sign; z = zero; nz = ~zero; gz = ~sign & ~zero; gez = ~sign; lez = sign | zero.
  - When acc_upd=0, flags hold.
  - Flags are visible the cycle after the update (1-cycle latency).
  - Flag invariants at all times: exactly one of {lz, z, gz} = 1; nz = ~z.
- Sticky overflow:
  - Set: acc_upd & ov_in.
  - Clear: ov_clr, or an accepted cond_req with cond_sel=7 (BV clears OV, TMS320 semantics).
  - Set and clear in the same cycle: set wins (ov=1).
- ov_cnt:
  - +1 on each set event; saturates at all-ones, no wrap.
  - ov_clr clears it to 0. A same-cycle set event then makes it 1.
  - BV does not touch ov_cnt.
- BIO: SYNC_STAGES-flop shift chain on bio; bioz = ~last stage. Pin-to-bioz latency is SYNC_STAGES cycles.
- Condition evaluation:
  - On an edge with cond_req=1, evaluate cond_sel against the current registered flags, ov, bioz and ar as presented.
  - A flag update in that same edge is not seen.
  - Next cycle: cond_valid=1 with cond_true. Otherwise cond_valid=0 and cond_true=0.
  - Back-to-back requests are accepted every cycle; no stall.
  - Encoding:
    - 0 B = 1
    - 1 BZ = z
    - 2 BNZ = nz
    - 3 BGZ = gz
    - 4 BGEZ = gez
    - 5 BLZ = lz
    - 6 BLEZ = lez
    - 7 BV = ov
    - 8 BANZ = (ar != 0)
    - 9 BIOZ = bioz
    - 10-15 reserved: cond_true = 0
  - BV returns the pre-clear ov value, then clears ov (unless a set wins).

Test Plan:
- Reset: hold reset 2 cycles -> z=gez=lez=1, gz=lz=nz=ov=0, ov_cnt=0, bioz=0, cond_valid=0.
- Flags (ACC_W=32): acc_upd with accum=0x80000000 -> next cycle lz=lez=nz=1, z=gz=gez=0. accum=0x00000001 -> gz=gez=nz=1. accum=0 -> z=gez=lez=1. acc_upd=0 with accum=0xFFFFFFFF -> flags unchanged.
- Overflow: 17 updates with ov_in=1 (OVC_W=4) -> ov=1, ov_cnt=15 (saturated). ov_clr together with acc_upd&ov_in -> ov=1, ov_cnt=1.
- BV: ov=1, cond_req sel=7 -> next cycle cond_valid=1, cond_true=1, ov=0. Repeat next cycle -> cond_true=0.
- Conditions: ar=0 with sel=8 -> cond_true=0; ar=0x0005 -> 1. sel=12 -> cond_valid=1, cond_true=0. sel=1 issued in the same cycle as acc_upd accum=5 (prior z=1) -> cond_true=1 (old flags).
- BIO: drive bio 1->0 -> bioz rises exactly SYNC_STAGES cycles later. A 1-cycle bio glitch still propagates through the chain. reset asserted mid-chain -> bioz=0 next cycle.
